// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 1 start, WORD_LENGHT data bits (LSB first),
// 1 even-parity bit and 1 stop bit. Each received word is latched into a
// holding register, with parity, framing and overrun flags alongside it.
// Optional feature: define UART_RX_PARITY_CHECK_EN to compare the parity bit.
// When the macro is undefined the parity bit is still consumed, but
// Parity_error is tied low and no parity XOR tree is built.
module uart_rx #(
    parameter int WORD_LENGHT  = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    input  logic                   Rx_clear,
    output logic [WORD_LENGHT-1:0] Rx_out,
    output logic                   Rx_valid,
    output logic                   Parity_error,
    output logic                   Frame_error,
    output logic                   Overrun
);

    // Smallest r with 2**r >= value; sizes the data bit counter.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int BIT_CNT_W_RAW = ceil_log2(WORD_LENGHT);
    localparam int BIT_CNT_W     = (BIT_CNT_W_RAW < 1) ? 1 : BIT_CNT_W_RAW;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_LENGHT - 1);

    // Divider reloads: a countdown that reaches zero on the sampling edge.
    localparam logic [7:0] FULL_BIT_RELOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_BIT_RELOAD = 8'((CLKS_PER_BIT / 2) - 1);

    // With one clock per bit the start bit needs no mid-bit re-check.
    localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [7:0]             div_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [WORD_LENGHT-1:0] shift_reg;
    logic [WORD_LENGHT-1:0] shift_next;
    logic                   sample_now;

`ifdef UART_RX_PARITY_CHECK_EN
    logic parity_bit;
    logic parity_mismatch;

    // Even parity: the received parity bit must equal the XOR of the data.
    assign parity_mismatch = (^shift_reg) != parity_bit;
`else
    assign Parity_error = 1'b0;
`endif

    // The divider has reached the middle of the current bit.
    assign sample_now = (div_cnt == 8'd0);

    // Right-shift with the new bit entering at the MSB, so D0 ends in bit 0.
    always_comb begin
        shift_next = shift_reg >> 1;
        shift_next[WORD_LENGHT-1] = Rx_in;
    end

    // Receive state machine, holding register and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARM;
            div_cnt      <= 8'd0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            Rx_out       <= '0;
            Rx_valid     <= 1'b0;
            Frame_error  <= 1'b0;
            Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_bit   <= 1'b0;
            Parity_error <= 1'b0;
`endif
        end else begin
            if (Rx_clear) begin
                Rx_valid     <= 1'b0;
                Frame_error  <= 1'b0;
                Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
                Parity_error <= 1'b0;
`endif
            end

            case (state)
                ARM: begin
                    if (Rx_in) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!Rx_in) begin
                        bit_cnt <= '0;
                        if (SINGLE_CLK) begin
                            div_cnt <= FULL_BIT_RELOAD;
                            state   <= DATA;
                        end else begin
                            div_cnt <= HALF_BIT_RELOAD;
                            state   <= START;
                        end
                    end
                end

                START: begin
                    if (!sample_now) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!Rx_in) begin
                        div_cnt <= FULL_BIT_RELOAD;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end

                DATA: begin
                    if (sample_now) begin
                        shift_reg <= shift_next;
                        div_cnt   <= FULL_BIT_RELOAD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                PARITY: begin
                    if (sample_now) begin
`ifdef UART_RX_PARITY_CHECK_EN
                        parity_bit <= Rx_in;
`endif
                        div_cnt <= FULL_BIT_RELOAD;
                        state   <= STOP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                STOP: begin
                    if (sample_now) begin
                        Rx_out      <= shift_reg;
                        Rx_valid    <= 1'b1;
                        Frame_error <= ~Rx_in;
                        Overrun     <= Rx_clear ? 1'b0 : (Overrun | Rx_valid);
`ifdef UART_RX_PARITY_CHECK_EN
                        Parity_error <= parity_mismatch;
`endif
                        state <= Rx_in ? IDLE : ARM;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. One instance runs at one clock
// per bit and a second at sixteen clocks per bit; expected words and flags
// are hand-computed constants.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx1;
    logic       clr1;
    logic [7:0] out1;
    logic       valid1;
    logic       perr1;
    logic       ferr1;
    logic       ovr1;
    logic       rx16;
    logic       clr16;
    logic [7:0] out16;
    logic       valid16;
    logic       perr16;
    logic       ferr16;
    logic       ovr16;

    int compared   = 0;
    int mismatched = 0;
    int deliveries = 0;
    int snap       = 0;
    logic prev_valid = 1'b0;

`ifdef UART_RX_PARITY_CHECK_EN
    localparam logic EXP_PERR_ON_BAD = 1'b1;
`else
    localparam logic EXP_PERR_ON_BAD = 1'b0;
`endif

    uart_rx #(.WORD_LENGHT(8), .CLKS_PER_BIT(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .Rx_in        (rx1),
        .Rx_clear     (clr1),
        .Rx_out       (out1),
        .Rx_valid     (valid1),
        .Parity_error (perr1),
        .Frame_error  (ferr1),
        .Overrun      (ovr1)
    );

    uart_rx #(.WORD_LENGHT(8), .CLKS_PER_BIT(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .Rx_in        (rx16),
        .Rx_clear     (clr16),
        .Rx_out       (out16),
        .Rx_valid     (valid16),
        .Parity_error (perr16),
        .Frame_error  (ferr16),
        .Overrun      (ovr16)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of the 1x receiver's valid flag as deliveries.
    always @(negedge clk) begin
        deliveries <= deliveries + ((valid1 && !prev_valid) ? 1 : 0);
        prev_valid <= valid1;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Send one whole frame; bits change 1 unit after a rising edge.
    task automatic applyStimulus(input logic [7:0] data, input logic par,
                                 input logic stp, input int clks,
                                 input bit clr_on_stop);
        logic [10:0] frame;
        frame = {stp, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (clks == 1) begin
                rx1 = frame[i];
                if (clr_on_stop && i == 10) begin
                    clr1 = 1'b1;
                end
            end else begin
                rx16 = frame[i];
            end
            repeat (clks) @(posedge clk);
            #1;
            clr1 = 1'b0;
        end
    endtask

    // Hold both lines idle for n clocks.
    task automatic idle(input int n);
        rx1  = 1'b1;
        rx16 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the 1x line at a fixed level for n clocks.
    task automatic holdLine1(input logic level, input int n);
        rx1 = level;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-clock acknowledge pulse on the 1x receiver.
    task automatic pulseClear1();
        clr1 = 1'b1;
        @(posedge clk);
        #1;
        clr1 = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        logic [10:0] frame;
        rst   = 1'b0;
        rx1   = 1'b1;
        rx16  = 1'b1;
        clr1  = 1'b0;
        clr16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", {24'd0, out1}, 32'h0);
        checkOutput("reset_valid", {31'd0, valid1}, 32'h0);
        checkOutput("reset_flags", {29'd0, perr1, ferr1, ovr1}, 32'h0);
        rst = 1'b1;
        idle(3);

        // Frame A5: delivery exactly at the stop-sample edge, not before.
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx1 = frame[i];
            @(posedge clk);
            #1;
        end
        checkOutput("a5_valid_before_stop", {31'd0, valid1}, 32'h0);
        rx1 = frame[10];
        @(posedge clk);
        #1;
        checkOutput("a5_valid", {31'd0, valid1}, 32'h1);
        checkOutput("a5_out", {24'd0, out1}, 32'hA5);
        checkOutput("a5_flags", {29'd0, perr1, ferr1, ovr1}, 32'h0);
        pulseClear1();
        checkOutput("clear_valid", {31'd0, valid1}, 32'h0);
        checkOutput("clear_holds_out", {24'd0, out1}, 32'hA5);

        // Frame 01 with a wrong parity bit.
        applyStimulus(8'h01, 1'b0, 1'b1, 1, 1'b0);
        checkOutput("p01_out", {24'd0, out1}, 32'h01);
        checkOutput("p01_perr", {31'd0, perr1}, {31'd0, EXP_PERR_ON_BAD});
        checkOutput("p01_ferr", {31'd0, ferr1}, 32'h0);
        pulseClear1();
        checkOutput("p01_perr_cleared", {31'd0, perr1}, 32'h0);

        // Frame 3C with stop low, then a long low line, then frame 55.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1, 1'b0);
        checkOutput("f3c_out", {24'd0, out1}, 32'h3C);
        checkOutput("f3c_ferr", {31'd0, ferr1}, 32'h1);
        rx1 = 1'b0;
        pulseClear1();
        snap = deliveries;
        holdLine1(1'b0, 19);
        checkOutput("low_no_valid", {31'd0, valid1}, 32'h0);
        checkOutput("low_no_delivery", deliveries - snap, 32'h0);
        idle(3);
        applyStimulus(8'h55, 1'b0, 1'b1, 1, 1'b0);
        checkOutput("f55_out", {24'd0, out1}, 32'h55);
        checkOutput("f55_ferr", {31'd0, ferr1}, 32'h0);
        checkOutput("f55_valid", {31'd0, valid1}, 32'h1);

        // Back-to-back 11 then 22 without acknowledge.
        pulseClear1();
        idle(2);
        applyStimulus(8'h11, 1'b0, 1'b1, 1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1, 1, 1'b0);
        checkOutput("ovr_out", {24'd0, out1}, 32'h22);
        checkOutput("ovr_set", {31'd0, ovr1}, 32'h1);
        checkOutput("ovr_valid", {31'd0, valid1}, 32'h1);
        pulseClear1();
        checkOutput("ovr_cleared", {31'd0, ovr1}, 32'h0);

        // Same pair with acknowledge on the second delivery edge.
        idle(2);
        applyStimulus(8'h11, 1'b0, 1'b1, 1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1, 1, 1'b1);
        checkOutput("ack_ovr", {31'd0, ovr1}, 32'h0);
        checkOutput("ack_valid", {31'd0, valid1}, 32'h1);
        checkOutput("ack_out", {24'd0, out1}, 32'h22);

        // 16x receiver: a three-clock glitch, then a real frame C3.
        rx16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx16 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("glitch_no_valid", {31'd0, valid16}, 32'h0);
        applyStimulus(8'hC3, 1'b0, 1'b1, 16, 1'b0);
        idle(4);
        checkOutput("x16_out", {24'd0, out16}, 32'hC3);
        checkOutput("x16_valid", {31'd0, valid16}, 32'h1);
        checkOutput("x16_flags", {29'd0, perr16, ferr16, ovr16}, 32'h0);

        // Reset after D3 of a frame, low line on release, then frame 7E.
        pulseClear1();
        idle(2);
        snap = deliveries;
        frame = {1'b1, 1'b0, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx1 = frame[i];
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #2;
        checkOutput("mid_reset_out", {24'd0, out1}, 32'h0);
        checkOutput("mid_reset_out16", {24'd0, out16}, 32'h0);
        checkOutput("mid_reset_flags", {28'd0, valid1, perr1, ferr1, ovr1}, 32'h0);
        rx1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        holdLine1(1'b0, 5);
        checkOutput("post_reset_no_valid", {31'd0, valid1}, 32'h0);
        idle(2);
        applyStimulus(8'h7E, 1'b0, 1'b1, 1, 1'b0);
        idle(1);
        checkOutput("r7e_out", {24'd0, out1}, 32'h7E);
        checkOutput("r7e_valid", {31'd0, valid1}, 32'h1);
        checkOutput("r7e_ferr", {31'd0, ferr1}, 32'h0);
        checkOutput("r7e_one_delivery", deliveries - snap, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
